pos_cache_mu_wr_arbiter: RTL and testbench

- Collects motion-update (MU) results destined for one cell from NUM_REQ sources: the local MU unit, neighbour cells and remote-node receive paths.
- Buffers each source in a small FIFO and serialises the results round-robin onto the single MU write port of the cell's position cache (i_MU_wr_en/i_MU_wr_pos/i_MU_wr_element).
- Generates the cache's i_MU_working, deasserting it only after every source has signalled done and the last write has been issued.

---
 rtl/pos_cache_mu_wr_arbiter.sv | 196 +++++++++++++++++++
 tb/tb_pos_cache_mu_wr_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pos_cache_mu_wr_arbiter.sv
// Gathers motion-update results from NUM_REQ sources into per-source FIFOs and
// serialises them round-robin onto the position cache's single MU write port.
module pos_cache_mu_wr_arbiter #(
  parameter int unsigned NUM_REQ           = 4,
  parameter int unsigned FIFO_DEPTH        = 8,
  parameter int unsigned POS_W             = 24,
  parameter int unsigned ELEM_W            = 16,
  parameter int unsigned MAX_WRITES        = 63,
  parameter int unsigned PARTICLE_ID_WIDTH = $clog2(MAX_WRITES + 1)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         i_mu_start,
  input  logic [NUM_REQ-1:0]           i_req_valid,
  input  logic [NUM_REQ*POS_W-1:0]     i_req_pos,
  input  logic [NUM_REQ*ELEM_W-1:0]    i_req_element,
  input  logic [NUM_REQ-1:0]           i_req_done,
  output logic [NUM_REQ-1:0]           o_req_ready,
  output logic                         o_MU_wr_en,
  output logic [POS_W-1:0]             o_MU_wr_pos,
  output logic [ELEM_W-1:0]            o_MU_wr_element,
  output logic                         o_MU_working,
  output logic [PARTICLE_ID_WIDTH-1:0] o_wr_count,
  output logic                         o_overflow,
  output logic [1:0]                   o_state
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned OCC_W = PTR_W + 1;
  localparam int unsigned RR_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned DW    = POS_W + ELEM_W;
  localparam int unsigned CW    = PARTICLE_ID_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DRAIN   = 2'd2,
    S_FINISH  = 2'd3
  } state_t;

  state_t               r_state;
  logic [NUM_REQ-1:0]   r_done;
  logic [RR_W-1:0]      r_rr;
  logic                 r_working;
  logic                 r_wr_en;
  logic [POS_W-1:0]     r_wr_pos;
  logic [ELEM_W-1:0]    r_wr_elem;
  logic [CW-1:0]        r_wr_count;
  logic                 r_overflow;

  logic [DW-1:0]        r_mem  [NUM_REQ][FIFO_DEPTH];
  logic [PTR_W-1:0]     r_wptr [NUM_REQ];
  logic [PTR_W-1:0]     r_rptr [NUM_REQ];
  logic [OCC_W-1:0]     r_occ  [NUM_REQ];

  logic [NUM_REQ-1:0]   w_full;
  logic [NUM_REQ-1:0]   w_empty;
  logic [NUM_REQ-1:0]   w_push;
  logic [NUM_REQ-1:0]   w_pop;
  logic [NUM_REQ-1:0]   w_done_nxt;
  logic                 w_arb_en;
  logic                 w_gnt_vld;
  logic [RR_W-1:0]      w_gnt_idx;
  logic [RR_W-1:0]      w_scan;
  logic [RR_W-1:0]      w_rr_nxt;
  logic [DW-1:0]        w_rd_data;

  assign w_arb_en   = (r_state == S_COLLECT) || (r_state == S_DRAIN);
  assign w_done_nxt = r_done | i_req_done;

  // Per-source FIFO status and push qualification
  always_comb begin
    w_full  = '0;
    w_empty = '0;
    w_push  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_full[k]  = (r_occ[k] == OCC_W'(FIFO_DEPTH));
      w_empty[k] = (r_occ[k] == '0);
      w_push[k]  = (r_state == S_COLLECT) && i_req_valid[k] && !w_full[k];
    end
  end

  // Round-robin: first non-empty source at or after the pointer
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_scan    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_scan = RR_W'((int'(r_rr) + i) % int'(NUM_REQ));
      if (w_arb_en && !w_gnt_vld && !w_empty[w_scan]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = w_scan;
      end
    end
  end

  always_comb begin
    w_pop = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_pop[k] = w_gnt_vld && (w_gnt_idx == RR_W'(k));
    end
  end

  assign w_rr_nxt  = (w_gnt_idx == RR_W'(NUM_REQ - 1)) ? '0 : w_gnt_idx + RR_W'(1);
  assign w_rd_data = r_mem[w_gnt_idx][r_rptr[w_gnt_idx]];

  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_push[k]) begin
        r_mem[k][r_wptr[k]] <= {i_req_pos[k*POS_W +: POS_W], i_req_element[k*ELEM_W +: ELEM_W]};
      end
    end
  end

  // Pointer/occupancy bookkeeping; a simultaneous push and pop leaves occupancy unchanged
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        r_wptr[k] <= '0;
        r_rptr[k] <= '0;
        r_occ[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (w_push[k]) r_wptr[k] <= r_wptr[k] + PTR_W'(1);
        if (w_pop[k])  r_rptr[k] <= r_rptr[k] + PTR_W'(1);
        case ({w_push[k], w_pop[k]})
          2'b10:   r_occ[k] <= r_occ[k] + OCC_W'(1);
          2'b01:   r_occ[k] <= r_occ[k] - OCC_W'(1);
          default: r_occ[k] <= r_occ[k];
        endcase
      end
    end
  end

  // Phase FSM, write strobe and capacity tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_done     <= '0;
      r_rr       <= '0;
      r_working  <= 1'b0;
      r_wr_en    <= 1'b0;
      r_wr_pos   <= '0;
      r_wr_elem  <= '0;
      r_wr_count <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_wr_en <= 1'b0;
      if (w_gnt_vld) begin
        r_rr <= w_rr_nxt;
        if (r_wr_count == CW'(MAX_WRITES)) begin
          r_overflow <= 1'b1;
        end else begin
          r_wr_en    <= 1'b1;
          r_wr_pos   <= w_rd_data[DW-1 -: POS_W];
          r_wr_elem  <= w_rd_data[ELEM_W-1:0];
          r_wr_count <= r_wr_count + CW'(1);
        end
      end
      case (r_state)
        S_IDLE: begin
          if (i_mu_start) begin
            r_done     <= '0;
            r_wr_count <= '0;
            r_overflow <= 1'b0;
            r_working  <= 1'b1;
            r_state    <= S_COLLECT;
          end
        end
        S_COLLECT: begin
          r_done <= w_done_nxt;
          if (&w_done_nxt) r_state <= S_DRAIN;
        end
        S_DRAIN: begin
          if ((&w_empty) && !w_gnt_vld) begin
            r_working <= 1'b0;
            r_state   <= S_FINISH;
          end
        end
        S_FINISH: r_state <= S_IDLE;
        default:  r_state <= S_IDLE;
      endcase
    end
  end

  assign o_req_ready     = {NUM_REQ{r_state == S_COLLECT}} & ~w_full;
  assign o_MU_wr_en      = r_wr_en;
  assign o_MU_wr_pos     = r_wr_pos;
  assign o_MU_wr_element = r_wr_elem;
  assign o_MU_working    = r_working;
  assign o_wr_count      = r_wr_count;
  assign o_overflow      = r_overflow;
  assign o_state         = r_state;

endmodule

// File: tb/tb_pos_cache_mu_wr_arbiter.sv
// Directed bench for pos_cache_mu_wr_arbiter: a main instance plus a
// MAX_WRITES=4 instance (shared stimulus) for the capacity checks.
module tb_pos_cache_mu_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  valid;
  logic [3:0]  done;
  logic [31:0] pos_bus;
  logic [31:0] elem_bus;

  logic [3:0]  ready,    ov_ready;
  logic        wr_en,    ov_wr_en;
  logic [7:0]  wr_pos,   ov_wr_pos;
  logic [7:0]  wr_elem,  ov_wr_elem;
  logic        working,  ov_working;
  logic [4:0]  wr_count;
  logic [2:0]  ov_wr_count;
  logic        overflow, ov_overflow;
  logic [1:0]  state,    ov_state;

  pos_cache_mu_wr_arbiter #(
    .NUM_REQ(4), .FIFO_DEPTH(8), .POS_W(8), .ELEM_W(8),
    .MAX_WRITES(31), .PARTICLE_ID_WIDTH(5)
  ) dut (
    .clk(clk), .rst(rst), .i_mu_start(start),
    .i_req_valid(valid), .i_req_pos(pos_bus), .i_req_element(elem_bus),
    .i_req_done(done), .o_req_ready(ready),
    .o_MU_wr_en(wr_en), .o_MU_wr_pos(wr_pos), .o_MU_wr_element(wr_elem),
    .o_MU_working(working), .o_wr_count(wr_count), .o_overflow(overflow),
    .o_state(state)
  );

  pos_cache_mu_wr_arbiter #(
    .NUM_REQ(4), .FIFO_DEPTH(8), .POS_W(8), .ELEM_W(8),
    .MAX_WRITES(4), .PARTICLE_ID_WIDTH(3)
  ) dut_ov (
    .clk(clk), .rst(rst), .i_mu_start(start),
    .i_req_valid(valid), .i_req_pos(pos_bus), .i_req_element(elem_bus),
    .i_req_done(done), .o_req_ready(ov_ready),
    .o_MU_wr_en(ov_wr_en), .o_MU_wr_pos(ov_wr_pos), .o_MU_wr_element(ov_wr_elem),
    .o_MU_working(ov_working), .o_wr_count(ov_wr_count), .o_overflow(ov_overflow),
    .o_state(ov_state)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int fall_cyc = -1;
  logic prev_work = 1'b0;
  logic [7:0] q_pos[$];
  logic [7:0] q_elem[$];
  int         q_cyc[$];
  logic [7:0] qo_pos[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Write-port monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (wr_en) begin
      q_pos.push_back(wr_pos);
      q_elem.push_back(wr_elem);
      q_cyc.push_back(cyc);
    end
    if (ov_wr_en) qo_pos.push_back(ov_wr_pos);
    if (prev_work && !working) fall_cyc = cyc;
    prev_work = working;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] qp(input int i);
    return (i < q_pos.size()) ? q_pos[i] : 8'hxx;
  endfunction

  function automatic logic [7:0] qe(input int i);
    return (i < q_elem.size()) ? q_elem[i] : 8'hxx;
  endfunction

  function automatic logic [7:0] qop(input int i);
    return (i < qo_pos.size()) ? qo_pos[i] : 8'hxx;
  endfunction

  function automatic int qc(input int i);
    return (i < q_cyc.size()) ? q_cyc[i] : -100;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input int k, input logic [7:0] p);
    pos_bus[k*8 +: 8]  = p;
    elem_bus[k*8 +: 8] = ~p;
  endtask

  task automatic clear_q();
    q_pos.delete();
    q_elem.delete();
    q_cyc.delete();
    qo_pos.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0; valid = '0; done = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic start_phase();
    clear_q();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 60; i++) begin
      if (state == 2'd0) break;
      tick();
    end
    chk(tag, 32'(state), 32'd0);
  endtask

  initial begin
    int b2;
    int n2;
    int bad2;
    logic r2;

    rst = 1'b1; start = 1'b0; valid = '0; done = '0; pos_bus = '0; elem_bus = '0;

    // Reset values
    do_reset();
    chk("rst_state",    32'(state),    32'd0);
    chk("rst_working",  32'(working),  32'd0);
    chk("rst_wr_en",    32'(wr_en),    32'd0);
    chk("rst_wr_pos",   32'(wr_pos),   32'd0);
    chk("rst_wr_count", 32'(wr_count), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_ready",    32'(ready),    32'd0);

    // Basic: three beats from source 0
    start_phase();
    chk("basic_state_collect", 32'(state), 32'd1);
    chk("basic_working",       32'(working), 32'd1);
    chk("basic_ready",         32'(ready), 32'hF);
    valid = 4'b0001; done = 4'b1110; set_beat(0, 8'h11);
    tick();
    done = '0; set_beat(0, 8'h12);
    tick();
    set_beat(0, 8'h13);
    tick();
    valid = '0; done = 4'b0001;
    tick();
    done = '0;
    wait_idle("basic_idle");
    chk("basic_nwr",   32'(q_pos.size()), 32'd3);
    chk("basic_pos0",  32'(qp(0)), 32'h11);
    chk("basic_pos1",  32'(qp(1)), 32'h12);
    chk("basic_pos2",  32'(qp(2)), 32'h13);
    chk("basic_elem2", 32'(qe(2)), 32'hEC);
    chk("basic_count", 32'(wr_count), 32'd3);
    chk("basic_fall",  32'(fall_cyc), 32'(qc(2) + 1));

    // Fairness: 2 beats from each source
    do_reset();
    start_phase();
    valid = 4'hF;
    for (int k = 0; k < 4; k++) set_beat(k, 8'(k * 16));
    tick();
    for (int k = 0; k < 4; k++) set_beat(k, 8'(k * 16 + 1));
    tick();
    valid = '0; done = 4'hF;
    tick();
    done = '0;
    wait_idle("fair_idle");
    chk("fair_nwr", 32'(q_pos.size()), 32'd8);
    for (int i = 0; i < 8; i++) chk($sformatf("fair_order_%0d", i), 32'(qp(i)), 32'((i % 4) * 16 + i / 4));
    chk("fair_back_to_back", 32'(qc(7) - qc(0)), 32'd7);
    chk("fair_count", 32'(wr_count), 32'd8);

    // Backpressure: source 2 streams 10 beats, others 4 each
    do_reset();
    start_phase();
    b2 = 0;
    for (int j = 0; j < 40 && b2 < 10; j++) begin
      for (int k = 0; k < 4; k++) begin
        if (k != 2) begin
          valid[k] = (j < 4);
          set_beat(k, 8'(k * 16 + j));
        end
      end
      valid[2] = 1'b1;
      set_beat(2, 8'(32 + b2));
      r2 = ready[2];
      tick();
      if (r2) b2++;
    end
    valid = '0;
    chk("bp_accepted", 32'(b2), 32'd10);
    chk("bp_ready2_full", 32'(ready[2]), 32'd0);
    done = 4'hF;
    tick();
    done = '0;
    wait_idle("bp_idle");
    n2 = 0; bad2 = 0;
    for (int i = 0; i < q_pos.size(); i++) begin
      if (q_pos[i][7:4] == 4'd2) begin
        if (q_pos[i][3:0] != 4'(n2)) bad2++;
        n2++;
      end
    end
    chk("bp_src2_count", 32'(n2), 32'd10);
    chk("bp_src2_order_errs", 32'(bad2), 32'd0);
    chk("bp_total", 32'(q_pos.size()), 32'd22);
    chk("bp_count", 32'(wr_count), 32'd22);

    // Overflow: 6 beats into a MAX_WRITES=4 instance
    do_reset();
    start_phase();
    valid = 4'b0011; done = 4'b1100;
    set_beat(0, 8'h00); set_beat(1, 8'h10);
    tick();
    done = '0;
    set_beat(0, 8'h01); set_beat(1, 8'h11);
    tick();
    done = 4'b0011;
    set_beat(0, 8'h02); set_beat(1, 8'h12);
    tick();
    valid = '0; done = '0;
    wait_idle("ov_idle");
    chk("ov_nwr",      32'(qo_pos.size()), 32'd4);
    chk("ov_pos0",     32'(qop(0)), 32'h00);
    chk("ov_pos1",     32'(qop(1)), 32'h10);
    chk("ov_pos2",     32'(qop(2)), 32'h01);
    chk("ov_pos3",     32'(qop(3)), 32'h11);
    chk("ov_count",    32'(ov_wr_count), 32'd4);
    chk("ov_flag",     32'(ov_overflow), 32'd1);
    chk("ov_main_cnt", 32'(wr_count), 32'd6);
    chk("ov_main_flg", 32'(overflow), 32'd0);
    start_phase();
    chk("ov_restart_count", 32'(ov_wr_count), 32'd0);
    chk("ov_restart_flag",  32'(ov_overflow), 32'd0);
    chk("ov_restart_state", 32'(ov_state), 32'd1);
    done = 4'hF;
    tick();
    done = '0;
    wait_idle("ov_restart_idle");

    // Done coincident with final beat, then an empty phase
    do_reset();
    start_phase();
    valid = 4'b0010; done = 4'b1101; set_beat(1, 8'h5A);
    tick();
    done = 4'b0010; set_beat(1, 8'h5B);
    tick();
    valid = '0; done = '0;
    wait_idle("coinc_idle");
    chk("coinc_nwr",   32'(q_pos.size()), 32'd2);
    chk("coinc_last",  32'(qp(1)), 32'h5B);
    chk("coinc_count", 32'(wr_count), 32'd2);
    start_phase();
    done = 4'hF;
    chk("empty_collect", 32'({state, working}), 32'({2'd1, 1'b1}));
    tick();
    done = '0;
    chk("empty_drain",  32'({state, working}), 32'({2'd2, 1'b1}));
    tick();
    chk("empty_finish", 32'({state, working}), 32'({2'd3, 1'b0}));
    tick();
    chk("empty_idle",   32'(state), 32'd0);
    chk("empty_nwr",    32'(q_pos.size()), 32'd0);
    chk("empty_count",  32'(wr_count), 32'd0);

    // Reset in the middle of COLLECT
    start_phase();
    valid = 4'hF;
    for (int k = 0; k < 4; k++) set_beat(k, 8'(k * 16 + 8));
    tick();
    for (int k = 0; k < 4; k++) set_beat(k, 8'(k * 16 + 9));
    tick();
    valid = '0;
    rst = 1'b1;
    tick();
    chk("midrst_state",    32'(state),    32'd0);
    chk("midrst_working",  32'(working),  32'd0);
    chk("midrst_wr_en",    32'(wr_en),    32'd0);
    chk("midrst_wr_pos",   32'(wr_pos),   32'd0);
    chk("midrst_ready",    32'(ready),    32'd0);
    chk("midrst_count",    32'(wr_count), 32'd0);
    chk("midrst_overflow", 32'(overflow), 32'd0);
    rst = 1'b0;
    clear_q();
    for (int i = 0; i < 5; i++) tick();
    chk("midrst_no_wr", 32'(q_pos.size()), 32'd0);
    start_phase();
    valid = 4'b1000; done = 4'hF; set_beat(3, 8'h3A);
    tick();
    valid = '0; done = '0;
    wait_idle("fresh_idle");
    chk("fresh_nwr",   32'(q_pos.size()), 32'd1);
    chk("fresh_pos",   32'(qp(0)), 32'h3A);
    chk("fresh_count", 32'(wr_count), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
